// File: rtl/gpa_fhdo_vec_seq.sv
// Gradient vector sequencer: serialises {x,y,z,z2} vectors into DAC write words for gpa_fhdo_iface.
// Latency: accept to first valid_o pulse is 2 cycles with an empty pipeline; busy_i paces later words.
// Backpressure: one pending plus one active vector; vec_ready_o drops while the pending slot is full.
// Optional feature macro: GPA_SEQ_ADC_READBACK_EN appends an ADC readback word after every non-empty vector.
module gpa_fhdo_vec_seq #(
  // Must be >= 1; covers the cycles before the iface raises busy after a pulse
  parameter int unsigned GUARD_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [95:0] vec_i,
  input  logic [3:0]  mask_i,
  input  logic        vec_valid_i,
  output logic        vec_ready_o,
  output logic [31:0] data_o,
  output logic        valid_o,
  input  logic        busy_i,
  output logic        idle_o,
  output logic [31:0] vec_cnt_o
);

  localparam int unsigned GW = 8;
  localparam logic [GW-1:0] GUARD_LD = GW'(GUARD_CYC - 1);
  localparam logic [31:0] ADC_WORD = {5'b01000, 2'd0, 1'b0, 24'hC000};

`ifdef GPA_SEQ_ADC_READBACK_EN
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAITB, S_ISSUE_ADC} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAITB} state_t;
`endif

  // Lowest set mask bit at or above 'from'; result is {found, index}
  function automatic logic [2:0] next_ch(input logic [3:0] m, input int from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (i >= from)) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  state_t           state_q;
  logic             pend_full_q, pend_full_d;
  logic [95:0]      pend_vec_q;
  logic [3:0]       pend_mask_q;
  logic             rdy_q;
  logic [3:0][23:0] act_vec_q;
  logic [3:0]       act_mask_q;
  logic [1:0]       ch_q;
  logic [GW-1:0]    gcnt_q;
  logic [31:0]      data_q;
  logic             valid_q;
  logic [31:0]      cnt_q;
`ifdef GPA_SEQ_ADC_READBACK_EN
  logic             adc_q;
`endif

  logic       accept;
  logic       move;
  logic [2:0] first_ch;
  logic [2:0] more_ch;

  // Handshake decode and pending-slot next state; accept and move never coincide
  always_comb begin
    accept      = vec_valid_i && rdy_q;
    move        = (state_q == S_IDLE) && pend_full_q;
    pend_full_d = pend_full_q;
    if (accept)    pend_full_d = 1'b1;
    else if (move) pend_full_d = 1'b0;
    first_ch = next_ch(pend_mask_q, 0);
    more_ch  = next_ch(act_mask_q, int'(ch_q) + 1);
  end

  // Pending register: captures input only on accept; ready is registered from the next fill state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full_q <= 1'b0;
      pend_vec_q  <= '0;
      pend_mask_q <= '0;
      rdy_q       <= 1'b0;
    end else begin
      pend_full_q <= pend_full_d;
      rdy_q       <= !pend_full_d;
      if (accept) begin
        pend_vec_q  <= vec_i;
        pend_mask_q <= mask_i;
      end
    end
  end

  // Word sequencer FSM with registered data/valid and completed-vector counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      act_vec_q  <= '0;
      act_mask_q <= '0;
      ch_q       <= '0;
      gcnt_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
`ifdef GPA_SEQ_ADC_READBACK_EN
      adc_q      <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (move) begin
            act_vec_q  <= pend_vec_q;
            act_mask_q <= pend_mask_q;
            // An empty mask is dropped here without emitting or counting
            if (first_ch[2]) begin
              ch_q    <= first_ch[1:0];
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          valid_q <= 1'b1;
          // Update bit marks the highest enabled channel so all DACs change together
          data_q  <= {5'd0, ch_q, !more_ch[2], act_vec_q[ch_q]};
          gcnt_q  <= GUARD_LD;
          state_q <= S_GUARD;
        end
        S_GUARD: begin
          if (gcnt_q == '0) state_q <= S_WAITB;
          else              gcnt_q  <= gcnt_q - 1'b1;
        end
        S_WAITB: begin
          if (!busy_i) begin
`ifdef GPA_SEQ_ADC_READBACK_EN
            if (adc_q) begin
              adc_q   <= 1'b0;
              cnt_q   <= cnt_q + 1'b1;
              state_q <= S_IDLE;
            end else if (more_ch[2]) begin
              ch_q    <= more_ch[1:0];
              state_q <= S_ISSUE;
            end else begin
              state_q <= S_ISSUE_ADC;
            end
`else
            if (more_ch[2]) begin
              ch_q    <= more_ch[1:0];
              state_q <= S_ISSUE;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= S_IDLE;
            end
`endif
          end
        end
`ifdef GPA_SEQ_ADC_READBACK_EN
        S_ISSUE_ADC: begin
          valid_q <= 1'b1;
          data_q  <= ADC_WORD;
          adc_q   <= 1'b1;
          gcnt_q  <= GUARD_LD;
          state_q <= S_GUARD;
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign vec_ready_o = rdy_q;
  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign vec_cnt_o   = cnt_q;
  assign idle_o      = (state_q == S_IDLE) && !pend_full_q;

endmodule

// File: tb/tb_gpa_fhdo_vec_seq.sv
// Testbench for gpa_fhdo_vec_seq: scoreboard of expected DAC words plus a busy-pacing iface model.
module tb_gpa_fhdo_vec_seq;

  logic        clk;
  logic        rst_n;
  logic [95:0] vec_i;
  logic [3:0]  mask_i;
  logic        vec_valid_i;
  logic        vec_ready_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        busy_i;
  logic        idle_o;
  logic [31:0] vec_cnt_o;

  gpa_fhdo_vec_seq #(.GUARD_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .vec_i(vec_i), .mask_i(mask_i),
    .vec_valid_i(vec_valid_i), .vec_ready_o(vec_ready_o),
    .data_o(data_o), .valid_o(valid_o), .busy_i(busy_i),
    .idle_o(idle_o), .vec_cnt_o(vec_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  int          exp_cnt  = 0;
  int          words_seen = 0;
  int          busy_fix = 0;
  int          busy_cnt;
  logic        prev_v;
  logic [23:0] dac_lat[4];
  logic [23:0] dac_out[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Iface model: busy rises the cycle after a pulse and holds for the transfer time
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cnt <= 0;
    else if (valid_o) busy_cnt <= (busy_fix != 0) ? busy_fix : int'($urandom_range(1, 20));
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign busy_i = (busy_cnt != 0);

  // Monitor: pops expected words, checks pacing, and models the DAC latch/update
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (valid_o) begin
        words_seen++;
        chk("valid_gap", {31'd0, prev_v}, 32'd0);
        chk("busy_at_pulse", {31'd0, busy_i}, 32'd0);
        if (exp_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL unexpected_word: got %h expected none", data_o);
        end else begin
          chk("word", data_o, exp_q.pop_front());
        end
        if (data_o[31:27] == 5'd0) begin
          dac_lat[data_o[26:25]] = data_o[23:0];
          if (data_o[24]) for (int k = 0; k < 4; k++) dac_out[k] = dac_lat[k];
        end
      end
      prev_v = valid_o;
    end
  end

  // Reference model: one word per enabled channel, ascending, update on the highest
  task automatic push_model(input logic [95:0] v, input logic [3:0] m);
    logic [31:0] w;
    for (int c = 0; c < 4; c++) begin
      if (m[c]) begin
        w = {5'd0, 2'(c), ((m >> (c + 1)) == 4'd0), v[24*c +: 24]};
        exp_q.push_back(w);
      end
    end
`ifdef GPA_SEQ_ADC_READBACK_EN
    if (m != 4'd0) exp_q.push_back(32'h4000C000);
`endif
    if (m != 4'd0) exp_cnt++;
  endtask

  // Offer a vector at a negedge; returns at the negedge after it was accepted
  task automatic send(input logic [95:0] v, input logic [3:0] m);
    int t;
    t = 0;
    vec_i = v;
    mask_i = m;
    vec_valid_i = 1'b1;
    while (!vec_ready_o && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!vec_ready_o) begin
      chk("accept_timeout", {31'd0, vec_ready_o}, 32'd1);
    end else begin
      push_model(v, m);
      @(negedge clk);
    end
    vec_valid_i = 1'b0;
    vec_i = {$urandom, $urandom, $urandom};
    mask_i = 4'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (!(idle_o && exp_q.size() == 0 && !busy_i) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_drained"}, exp_q.size(), 32'd0);
    chk({name, "_idle"}, {31'd0, idle_o}, 32'd1);
    chk({name, "_vec_cnt"}, vec_cnt_o, exp_cnt);
  endtask

  initial begin
    logic [95:0] v;
    int target;
    int t;
    rst_n = 1'b0;
    vec_valid_i = 1'b0;
    vec_i = '0;
    mask_i = '0;
    for (int k = 0; k < 4; k++) begin dac_lat[k] = '0; dac_out[k] = '0; end

    // Reset values
    repeat (5) @(negedge clk);
    chk("rst_data", data_o, 32'd0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_ready", {31'd0, vec_ready_o}, 32'd0);
    chk("rst_idle", {31'd0, idle_o}, 32'd1);
    chk("rst_cnt", vec_cnt_o, 32'd0);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", {31'd0, vec_ready_o}, 32'd0);
    @(negedge clk);
    chk("ready_after_release", {31'd0, vec_ready_o}, 32'd1);

    // Full vector with slow iface
    busy_fix = 33;
    send({24'd4, 24'd3, 24'd2, 24'd1}, 4'hF);
    wait_idle("full");
    chk("dac_x", {8'd0, dac_out[0]}, 32'd1);
    chk("dac_y", {8'd0, dac_out[1]}, 32'd2);
    chk("dac_z", {8'd0, dac_out[2]}, 32'd3);
    chk("dac_z2", {8'd0, dac_out[3]}, 32'd4);

    // Sparse mask: y and z2 must keep their earlier values
    busy_fix = 0;
    send({24'h222, 24'hC, 24'h111, 24'hA}, 4'b0101);
    wait_idle("sparse");
    chk("sparse_x", {8'd0, dac_out[0]}, 32'hA);
    chk("sparse_y", {8'd0, dac_out[1]}, 32'd2);
    chk("sparse_z", {8'd0, dac_out[2]}, 32'hC);
    chk("sparse_z2", {8'd0, dac_out[3]}, 32'd4);

    // Back-to-back A, B, C
    send({24'h0A3, 24'h0A2, 24'h0A1, 24'h0A0}, 4'hF);
    send({24'h0B3, 24'h0B2, 24'h0B1, 24'h0B0}, 4'b1010);
    chk("ready_held", {31'd0, vec_ready_o}, 32'd0);
    send({24'h0C3, 24'h0C2, 24'h0C1, 24'h0C0}, 4'b0011);
    wait_idle("b2b");

    // Mask zero is discarded
    send({$urandom, $urandom, $urandom}, 4'h0);
    repeat (5) @(negedge clk);
    wait_idle("mask0");

    // Reset during the second word of a full vector
    busy_fix = 6;
    target = words_seen + 2;
    send({24'h333, 24'h222, 24'h111, 24'h000}, 4'hF);
    t = 0;
    while (words_seen < target && t < 2000) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("second_word_seen", words_seen, target);
    chk("valid_before_reset", {31'd0, valid_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("valid_async_reset", {31'd0, valid_o}, 32'd0);
    chk("data_async_reset", data_o, 32'd0);
    chk("idle_async_reset", {31'd0, idle_o}, 32'd1);
    exp_q.delete();
    exp_cnt = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    wait_idle("post_reset");

    // Randomized traffic with random iface busy time
    busy_fix = 0;
    for (int n = 0; n < 120; n++) begin
      v = {$urandom, $urandom, $urandom};
      send(v, 4'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
